// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: multi-precision add/sub/and/or sequencer that drives an
// external 8-bit ALU one byte-slice per cycle, least-significant byte first.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 request, sampled only in IDLE
//   i_op                    0 add, 1 sub, 2 and, 3 or
//   i_c_init                carry/borrow into byte 0 (add/sub only)
//   i_a_in, i_b_in          NBYTES-wide operands, latched on accept
//   o_busy                  high from the cycle after accept through DONE
//   o_done                  one-cycle completion pulse
//   o_result                wide result, holds until overwritten in RUN
//   o_c_flag/z_flag/n_flag  aggregate carry/borrow, zero, negative
//   o_alu_in1/in2/c_in/opcode  ALU request (combinational from state)
//   i_alu_out, i_alu_c_out  ALU result byte and carry/borrow out
module alu_mp_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic                  i_c_init,
  input  logic [8*NBYTES-1:0]   i_a_in,
  input  logic [8*NBYTES-1:0]   i_b_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [8*NBYTES-1:0]   o_result,
  output logic                  o_c_flag,
  output logic                  o_z_flag,
  output logic                  o_n_flag,
  output logic [7:0]            o_alu_in1,
  output logic [7:0]            o_alu_in2,
  output logic                  o_alu_c_in,
  output logic [2:0]            o_alu_opcode,
  input  logic [7:0]            i_alu_out,
  input  logic                  i_alu_c_out
);

  // ALU function codes (shared with the ALU's defines).
  localparam logic [2:0] ADD_FN  = 3'd0;
  localparam logic [2:0] ADDC_FN = 3'd1;
  localparam logic [2:0] SUB_FN  = 3'd2;
  localparam logic [2:0] SUBC_FN = 3'd3;
  localparam logic [2:0] AND_FN  = 3'd4;
  localparam logic [2:0] OR_FN   = 3'd5;

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_op;
  logic            r_c_init;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_zacc;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_result;
  logic            r_c_flag;
  logic            r_z_flag;
  logic            r_n_flag;

  logic            w_accept;
  logic            w_run;
  logic            w_last;
  logic            w_arith;
  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic [7:0]      w_alu_in1;
  logic [7:0]      w_alu_in2;
  logic            w_alu_c_in;
  logic [2:0]      w_alu_opcode;
  logic            w_zacc_next;

  // add/sub chain a carry; and/or do not
  assign w_arith  = ~r_op[1];
  assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
  assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];
  assign w_zacc_next = r_zacc | (|i_alu_out);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and ALU request; ALU is idle (0/0/0/ADD) outside RUN.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_run        = 1'b0;
    w_last       = 1'b0;
    w_alu_in1    = 8'd0;
    w_alu_in2    = 8'd0;
    w_alu_c_in   = 1'b0;
    w_alu_opcode = ADD_FN;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_run     = 1'b1;
        w_last    = (r_idx == LAST_IDX);
        w_alu_in1 = w_a_byte;
        w_alu_in2 = w_b_byte;
        unique case (r_op)
          2'd0:    w_alu_opcode = ADDC_FN;
          2'd1:    w_alu_opcode = SUBC_FN;
          2'd2:    w_alu_opcode = AND_FN;
          default: w_alu_opcode = OR_FN;
        endcase
        if (w_arith) begin
          w_alu_c_in = (r_idx == '0) ? r_c_init : r_carry;
        end
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, byte capture, carry chain and flag assembly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'd0;
      r_c_init <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_c_flag <= 1'b0;
      r_z_flag <= 1'b0;
      r_n_flag <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= i_a_in;
        r_b      <= i_b_in;
        r_op     <= i_op;
        r_c_init <= i_c_init;
        r_idx    <= '0;
        r_carry  <= 1'b0;
        r_zacc   <= 1'b0;
        r_busy   <= 1'b1;
      end
      if (w_run) begin
        r_result[{r_idx, 3'b000} +: 8] <= i_alu_out;
        if (w_arith) begin
          r_carry <= i_alu_c_out;
        end
        r_zacc <= w_zacc_next;
        if (w_last) begin
          r_idx    <= '0;
          r_done   <= 1'b1;
          r_c_flag <= w_arith ? i_alu_c_out : 1'b0;
          r_z_flag <= ~w_zacc_next;
          // the last byte captured holds the result MSB
          r_n_flag <= i_alu_out[7];
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
      if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_result     = r_result;
  assign o_c_flag     = r_c_flag;
  assign o_z_flag     = r_z_flag;
  assign o_n_flag     = r_n_flag;
  assign o_alu_in1    = w_alu_in1;
  assign o_alu_in2    = w_alu_in2;
  assign o_alu_c_in   = w_alu_c_in;
  assign o_alu_opcode = w_alu_opcode;

endmodule
